// File: rtl/cam_pkg.sv
// ----------------------------------------------------------------------------
// cam_pkg
// Shared types and constants for the camera pixel framer:
//   state_t          framer FSM states (IDLE, FRAME, DONE)
//   ERR_*            bit positions inside err_o
//   R_/G_/B_ HI/LO   RGB565 field slices
//   LUMA_*           fixed-point luma weights (sum to 256)
// ----------------------------------------------------------------------------
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ERR_SHORT_LINE  = 0;
    localparam int ERR_LONG_LINE   = 1;
    localparam int ERR_SHORT_FRAME = 2;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;

endpackage

// File: rtl/cam_pixel_framer_rgb565_to_luma.sv
// ----------------------------------------------------------------------------
// rgb565_to_luma
// Combinational RGB565 -> 8-bit luma conversion.
// Each field is widened to 8 bits by replicating its MSBs, then weighted by
// 77/150/29 and divided by 256. Full white maps exactly to 8'hFF.
// Ports:
//   pix_i   in  16  RGB565 pixel
//   luma_o  out  8  luma value
// ----------------------------------------------------------------------------
module rgb565_to_luma
    import cam_pkg::*;
(
    input  logic [15:0] pix_i,
    output logic [7:0]  luma_o
);

    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;

    assign r5 = pix_i[R_HI:R_LO];
    assign g6 = pix_i[G_HI:G_LO];
    assign b5 = pix_i[B_HI:B_LO];

    assign r8 = {r5, r5[4:2]};
    assign g8 = {g6, g6[5:4]};
    assign b8 = {b5, b5[4:2]};

    // Weights sum to 256, so the maximum sum is 255*256 and fits 16 bits.
    assign sum = 16'(LUMA_R) * 16'(r8)
               + 16'(LUMA_G) * 16'(g8)
               + 16'(LUMA_B) * 16'(b8);

    assign luma_o = 8'(sum >> 8);

endmodule

// File: rtl/cam_pixel_framer.sv
// ----------------------------------------------------------------------------
// cam_pixel_framer
// Assigns x/y coordinates to the assembled RGB565 pixel stream, applies a
// static crop window and emits a framed stream with sof/eol/eof sidebands.
// Geometry errors are reported as one-cycle pulses on err_o.
// All outputs are registered: one cycle latency from the accepted pixel.
//
// Optional build macro: CAM_PIXEL_FRAMER_GRAY_EN
//   defined   -> out_pixel_o = {8'h00, luma(pix_i)}
//   undefined -> out_pixel_o = pix_i
//
// Ports:
//   pclk_i       in   1   pixel clock
//   rst_i        in   1   asynchronous active-low reset
//   pix_valid_i  in   1   one-cycle strobe per pixel
//   pix_i        in  16   RGB565 pixel
//   vstart_i     in   1   frame-start pulse
//   hstart_i     in   1   line-start marker, coincident with first pixel
//   out_valid_o  out  1   cropped pixel valid
//   out_pixel_o  out 16   cropped pixel
//   x_o          out XW   column relative to CROP_X0
//   y_o          out YW   row relative to CROP_Y0
//   sof_o        out  1   first cropped pixel of frame
//   eol_o        out  1   last cropped pixel of line
//   eof_o        out  1   last cropped pixel of frame
//   err_o        out  3   [0] short line, [1] long line, [2] short frame
// ----------------------------------------------------------------------------
module cam_pixel_framer #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int CROP_X0 = 0,
    parameter int CROP_Y0 = 0,
    parameter int CROP_W  = 640,
    parameter int CROP_H  = 480,
    parameter int XW      = 11,
    parameter int YW      = 10
) (
    input  logic          pclk_i,
    input  logic          rst_i,
    input  logic          pix_valid_i,
    input  logic [15:0]   pix_i,
    input  logic          vstart_i,
    input  logic          hstart_i,
    output logic          out_valid_o,
    output logic [15:0]   out_pixel_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          eof_o,
    output logic [2:0]    err_o
);

    import cam_pkg::*;

    localparam logic [XW-1:0] X_END   = XW'(IMG_W);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_LO    = XW'(CROP_X0);
    localparam logic [YW-1:0] Y_LO    = YW'(CROP_Y0);
    localparam logic [XW-1:0] CW      = XW'(CROP_W);
    localparam logic [YW-1:0] CH      = YW'(CROP_H);
    localparam logic [XW-1:0] CW_LAST = XW'(CROP_W - 1);
    localparam logic [YW-1:0] CH_LAST = YW'(CROP_H - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          accept;
    logic [2:0]    err_d;

    logic [XW-1:0] x_rel;
    logic [YW-1:0] y_rel;
    logic          in_crop;
    logic          eol_d;
    logic [15:0]   pix_out;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        px      = x_q;
        py      = y_q;
        accept  = 1'b0;
        err_d   = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (vstart_i) begin
                    state_d = FRAME;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            FRAME: begin
                if (vstart_i) begin
                    // Frame restarts; any pixel in this cycle is dropped.
                    err_d[ERR_SHORT_FRAME] = 1'b1;
                    x_d = '0;
                    y_d = '0;
                end else if (pix_valid_i) begin
                    if (hstart_i) begin
                        px     = '0;
                        accept = 1'b1;
                        // x==0 means the first line of the frame: y stays.
                        if (x_q != '0) begin
                            py = y_q + 1'b1;
                            if (x_q != X_END) begin
                                err_d[ERR_SHORT_LINE] = 1'b1;
                            end
                        end
                    end else if (x_q == X_END) begin
                        // Extra pixel past the line end: drop it, x saturates.
                        err_d[ERR_LONG_LINE] = 1'b1;
                    end else begin
                        accept = 1'b1;
                    end

                    if (accept) begin
                        x_d = px + 1'b1;
                        y_d = py;
                        if (x_d == X_END && py == Y_LAST) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A coordinate left of (or above) the window wraps to a value far beyond
    // the crop size, so a single unsigned compare covers both window edges.
    assign x_rel   = px - X_LO;
    assign y_rel   = py - Y_LO;
    assign in_crop = accept && (x_rel < CW) && (y_rel < CH);
    assign eol_d   = in_crop && (x_rel == CW_LAST);

`ifdef CAM_PIXEL_FRAMER_GRAY_EN
    logic [7:0] luma;

    rgb565_to_luma u_luma (
        .pix_i  (pix_i),
        .luma_o (luma)
    );

    assign pix_out = {8'h00, luma};
`else
    assign pix_out = pix_i;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // NOTE: the data/coordinate registers are reset too, so every output
    // reads 0 after reset, not just the qualifying valid.
    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_o <= 1'b0;
            out_pixel_o <= '0;
            x_o         <= '0;
            y_o         <= '0;
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
            eof_o       <= 1'b0;
            err_o       <= '0;
        end else begin
            out_valid_o <= in_crop;
            sof_o       <= in_crop && (x_rel == '0) && (y_rel == '0);
            eol_o       <= eol_d;
            eof_o       <= eol_d && (y_rel == CH_LAST);
            err_o       <= err_d;
            if (in_crop) begin
                out_pixel_o <= pix_out;
                x_o         <= x_rel;
                y_o         <= y_rel;
            end
        end
    end

endmodule

// File: tb/tb_cam_pixel_framer.sv
// ----------------------------------------------------------------------------
// tb_cam_pixel_framer
// Two framers on one input stream: full-frame (8x4) and cropped
// (X0=2, Y0=1, W=3, H=2). Expected outputs are queued as pixels are driven
// and popped when each instance presents out_valid_o.
// ----------------------------------------------------------------------------
module tb_cam_pixel_framer;

    import cam_pkg::*;

    localparam int W = 8;
    localparam int H = 4;

    localparam logic [2:0] E_NONE = 3'b000;
    localparam logic [2:0] E_SL   = 3'(1 << ERR_SHORT_LINE);
    localparam logic [2:0] E_LL   = 3'(1 << ERR_LONG_LINE);
    localparam logic [2:0] E_SF   = 3'(1 << ERR_SHORT_FRAME);

    logic        pclk_i = 1'b0;
    logic        rst_i  = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic [15:0] pix_i = '0;
    logic        vstart_i = 1'b0;
    logic        hstart_i = 1'b0;

    logic        f_valid, f_sof, f_eol, f_eof;
    logic [15:0] f_pix;
    logic [10:0] f_x;
    logic [9:0]  f_y;
    logic [2:0]  f_err;

    logic        c_valid, c_sof, c_eol, c_eof;
    logic [15:0] c_pix;
    logic [10:0] c_x;
    logic [9:0]  c_y;
    logic [2:0]  c_err;

    always #5 pclk_i = ~pclk_i;

    cam_pixel_framer #(
        .IMG_W(W), .IMG_H(H), .CROP_X0(0), .CROP_Y0(0), .CROP_W(W), .CROP_H(H),
        .XW(11), .YW(10)
    ) u_full (
        .pclk_i(pclk_i), .rst_i(rst_i), .pix_valid_i(pix_valid_i), .pix_i(pix_i),
        .vstart_i(vstart_i), .hstart_i(hstart_i),
        .out_valid_o(f_valid), .out_pixel_o(f_pix), .x_o(f_x), .y_o(f_y),
        .sof_o(f_sof), .eol_o(f_eol), .eof_o(f_eof), .err_o(f_err)
    );

    cam_pixel_framer #(
        .IMG_W(W), .IMG_H(H), .CROP_X0(2), .CROP_Y0(1), .CROP_W(3), .CROP_H(2),
        .XW(11), .YW(10)
    ) u_crop (
        .pclk_i(pclk_i), .rst_i(rst_i), .pix_valid_i(pix_valid_i), .pix_i(pix_i),
        .vstart_i(vstart_i), .hstart_i(hstart_i),
        .out_valid_o(c_valid), .out_pixel_o(c_pix), .x_o(c_x), .y_o(c_y),
        .sof_o(c_sof), .eol_o(c_eol), .eof_o(c_eof), .err_o(c_err)
    );

    typedef struct packed {
        logic [15:0] pix;
        logic [10:0] x;
        logic [9:0]  y;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t q_full[$];
    exp_t q_crop[$];

    int tests = 0;
    int fails = 0;
    logic [2:0] err_pend = E_NONE;

    int nv_f, ns_f, ne_f, nf_f;
    int nv_c, ns_c, ne_c, nf_c;

    function automatic logic [15:0] exp_pix(input logic [15:0] p);
`ifdef CAM_PIXEL_FRAMER_GRAY_EN
        logic [7:0] r8, g8, b8;
        int s;
        r8 = {p[15:11], p[15:13]};
        g8 = {p[10:5], p[10:9]};
        b8 = {p[4:0], p[4:2]};
        s  = 77 * int'(r8) + 150 * int'(g8) + 29 * int'(b8);
        return {8'h00, 8'(s >> 8)};
`else
        return p;
`endif
    endfunction

    // Expected output of each instance for an input pixel at sensor (x, y).
    task automatic expect_px(input int x, input int y, input logic [15:0] p);
        exp_t e;
        e.pix = exp_pix(p);
        e.x   = 11'(x);
        e.y   = 10'(y);
        e.sof = (x == 0 && y == 0);
        e.eol = (x == W - 1);
        e.eof = (x == W - 1 && y == H - 1);
        q_full.push_back(e);
        if (x >= 2 && x < 5 && y >= 1 && y < 3) begin
            e.x   = 11'(x - 2);
            e.y   = 10'(y - 1);
            e.sof = (x == 2 && y == 1);
            e.eol = (x == 4);
            e.eof = (x == 4 && y == 2);
            q_crop.push_back(e);
        end
    endtask

    // One clock: score the outputs produced by the previous cycle's inputs,
    // then drive this cycle's inputs and queue what they should produce.
    task automatic step(input logic v, input logic hs, input logic vs,
                        input logic [15:0] p, input logic [2:0] e_err,
                        input logic keep, input int x, input int y);
        exp_t got, e;
        @(negedge pclk_i);

        tests++;
        if (f_err !== err_pend) begin
            fails++;
            $display("FAIL err_full: got %b expected %b", f_err, err_pend);
        end
        tests++;
        if (c_err !== err_pend) begin
            fails++;
            $display("FAIL err_crop: got %b expected %b", c_err, err_pend);
        end

        tests++;
        if (f_valid === 1'b1) begin
            nv_f++; ns_f += int'(f_sof); ne_f += int'(f_eol); nf_f += int'(f_eof);
            got = {f_pix, f_x, f_y, f_sof, f_eol, f_eof};
            if (q_full.size() == 0) begin
                fails++;
                $display("FAIL out_full: unexpected pixel x=%0d y=%0d", f_x, f_y);
            end else begin
                e = q_full.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL out_full: got pix=%h x=%0d y=%0d s/e/f=%b%b%b expected pix=%h x=%0d y=%0d s/e/f=%b%b%b",
                             got.pix, got.x, got.y, got.sof, got.eol, got.eof,
                             e.pix, e.x, e.y, e.sof, e.eol, e.eof);
                end
            end
        end else if (f_valid !== 1'b0 || {f_sof, f_eol, f_eof} !== 3'b000) begin
            fails++;
            $display("FAIL side_full: valid=%b s/e/f=%b%b%b expected all 0",
                     f_valid, f_sof, f_eol, f_eof);
        end

        tests++;
        if (c_valid === 1'b1) begin
            nv_c++; ns_c += int'(c_sof); ne_c += int'(c_eol); nf_c += int'(c_eof);
            got = {c_pix, c_x, c_y, c_sof, c_eol, c_eof};
            if (q_crop.size() == 0) begin
                fails++;
                $display("FAIL out_crop: unexpected pixel x=%0d y=%0d", c_x, c_y);
            end else begin
                e = q_crop.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL out_crop: got pix=%h x=%0d y=%0d s/e/f=%b%b%b expected pix=%h x=%0d y=%0d s/e/f=%b%b%b",
                             got.pix, got.x, got.y, got.sof, got.eol, got.eof,
                             e.pix, e.x, e.y, e.sof, e.eol, e.eof);
                end
            end
        end else if (c_valid !== 1'b0 || {c_sof, c_eol, c_eof} !== 3'b000) begin
            fails++;
            $display("FAIL side_crop: valid=%b s/e/f=%b%b%b expected all 0",
                     c_valid, c_sof, c_eol, c_eof);
        end

        pix_valid_i = v;
        hstart_i    = hs;
        vstart_i    = vs;
        pix_i       = p;
        err_pend    = e_err;
        if (keep) expect_px(x, y, p);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0000, E_NONE, 1'b0, 0, 0);
    endtask

    task automatic vstart(input logic [2:0] e_err);
        step(1'b0, 1'b0, 1'b1, 16'h0000, e_err, 1'b0, 0, 0);
        idle();
    endtask

    // n pixels with hstart on the first; pixels past W are long-line drops.
    // gap_at inserts an hstart-without-valid cycle before that pixel index.
    task automatic send_line(input int y, input int n, input logic [2:0] first_err,
                             input int gap_at, input logic exp_on);
        logic [15:0] p;
        logic [2:0]  e;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) step(1'b0, 1'b1, 1'b0, 16'h0000, E_NONE, 1'b0, 0, 0);
            p = 16'($urandom_range(0, 65535));
            e = (i == 0) ? first_err : ((i >= W) ? E_LL : E_NONE);
            step(1'b1, (i == 0), 1'b0, p, e, exp_on && (i < W), i, y);
        end
        idle();
    endtask

    task automatic clear_counts();
        nv_f = 0; ns_f = 0; ne_f = 0; nf_f = 0;
        nv_c = 0; ns_c = 0; ne_c = 0; nf_c = 0;
    endtask

    task automatic flush(input string name);
        repeat (3) idle();
        tests++;
        if (q_full.size() != 0 || q_crop.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d/%0d expected pixels never appeared, required 0/0",
                     name, q_full.size(), q_crop.size());
        end
        q_full.delete();
        q_crop.delete();
    endtask

    task automatic count_check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(negedge pclk_i);
        tests++;
        if ({f_valid, f_pix, f_x, f_y, f_sof, f_eol, f_eof, f_err} !== '0 ||
            {c_valid, c_pix, c_x, c_y, c_sof, c_eol, c_eof, c_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: full valid=%b pix=%h err=%b crop valid=%b pix=%h err=%b, expected all 0",
                     f_valid, f_pix, f_err, c_valid, c_pix, c_err);
        end
        rst_i = 1'b1;
        clear_counts();
        // No vstart yet: the framer is in IDLE and must ignore all of this.
        send_line(0, W, E_NONE, -1, 1'b0);
        send_line(1, W, E_NONE, -1, 1'b0);
        flush("reset_idle");
        count_check("reset_idle_valid_full", nv_f, 0);
        count_check("reset_idle_valid_crop", nv_c, 0);
    endtask

    task automatic test_full_frame();
        clear_counts();
        vstart(E_NONE);
        for (int l = 0; l < H; l++) send_line(l, W, E_NONE, -1, 1'b1);
        flush("full_frame");
        count_check("full_valid", nv_f, 32);
        count_check("full_sof", ns_f, 1);
        count_check("full_eol", ne_f, 4);
        count_check("full_eof", nf_f, 1);
        count_check("crop_valid", nv_c, 6);
        count_check("crop_sof", ns_c, 1);
        count_check("crop_eol", ne_c, 2);
        count_check("crop_eof", nf_c, 1);
        // Frame complete: further pixels before vstart are ignored.
        send_line(0, W, E_NONE, -1, 1'b0);
        flush("done_ignore");
        count_check("done_ignore_valid", nv_f, 32);
    endtask

    task automatic test_short_line();
        clear_counts();
        vstart(E_NONE);
        send_line(0, W, E_NONE, -1, 1'b1);
        send_line(1, 5, E_NONE, -1, 1'b1);
        send_line(2, W, E_SL, -1, 1'b1);
        send_line(3, W, E_NONE, -1, 1'b1);
        flush("short_line");
        count_check("short_line_valid", nv_f, 29);
        count_check("short_line_eol", ne_f, 3);
        count_check("short_line_eof", nf_f, 1);
        count_check("short_line_crop_valid", nv_c, 6);
    endtask

    task automatic test_long_line();
        clear_counts();
        vstart(E_NONE);
        send_line(0, W + 1, E_NONE, -1, 1'b1);
        send_line(1, W, E_NONE, 4, 1'b1);
        send_line(2, W, E_NONE, -1, 1'b1);
        send_line(3, W, E_NONE, -1, 1'b1);
        flush("long_line");
        count_check("long_line_valid", nv_f, 32);
        count_check("long_line_eol", ne_f, 4);
        count_check("long_line_eof", nf_f, 1);
    endtask

    task automatic test_short_frame();
        clear_counts();
        vstart(E_NONE);
        send_line(0, W, E_NONE, -1, 1'b1);
        send_line(1, W, E_NONE, -1, 1'b1);
        // vstart coincident with a pixel: restart wins, pixel dropped.
        step(1'b1, 1'b1, 1'b1, 16'hA5A5, E_SF, 1'b0, 0, 0);
        idle();
        for (int l = 0; l < H; l++) send_line(l, W, E_NONE, -1, 1'b1);
        flush("short_frame");
        count_check("short_frame_valid", nv_f, 48);
        count_check("short_frame_sof", ns_f, 2);
        count_check("short_frame_eof", nf_f, 1);
        count_check("short_frame_crop_valid", nv_c, 9);
        count_check("short_frame_crop_sof", ns_c, 2);
        count_check("short_frame_crop_eof", nf_c, 1);
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        vstart(E_NONE);
        send_line(0, W, E_NONE, -1, 1'b1);
        send_line(1, 4, E_NONE, -1, 1'b1);
        idle();
        rst_i = 1'b0;
        #2;
        tests++;
        if ({f_valid, f_x, f_y, f_err, c_valid, c_err} !== '0) begin
            fails++;
            $display("FAIL midframe_reset: full valid=%b x=%0d y=%0d crop valid=%b, expected 0",
                     f_valid, f_x, f_y, c_valid);
        end
        @(negedge pclk_i);
        rst_i = 1'b1;
        err_pend = E_NONE;
        q_full.delete();
        q_crop.delete();
        clear_counts();
        send_line(1, W, E_NONE, -1, 1'b0);
        flush("after_reset");
        count_check("after_reset_valid", nv_f, 0);
        vstart(E_NONE);
        for (int l = 0; l < H; l++) send_line(l, W, E_NONE, -1, 1'b1);
        flush("recover");
        count_check("recover_valid", nv_f, 32);
        count_check("recover_eof", nf_f, 1);
    endtask

`ifdef CAM_PIXEL_FRAMER_GRAY_EN
    task automatic test_gray();
        vstart(E_NONE);
        step(1'b1, 1'b1, 1'b0, 16'hFFFF, E_NONE, 1'b1, 0, 0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, E_NONE, 1'b1, 1, 0);
        tests++;
        if (f_pix !== 16'h00FF) begin
            fails++;
            $display("FAIL gray_white: got %h expected 00ff", f_pix);
        end
        idle();
        tests++;
        if (f_pix !== 16'h0000) begin
            fails++;
            $display("FAIL gray_black: got %h expected 0000", f_pix);
        end
        flush("gray");
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_short_line();
        test_long_line();
        test_short_frame();
        test_reset_midframe();
`ifdef CAM_PIXEL_FRAMER_GRAY_EN
        test_gray();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
